memwrite_sequence_checker: RTL

// - Synthesizable, parametrised self-checker for MIPS processor benches and FPGA bring-up.
// - Watches the data-memory write port and matches successive writes against an ordered

---
 rtl/memwrite_check_pkg.sv | 10 +
 rtl/memwrite_entry_mux.sv | 27 ++
 rtl/memwrite_sequence_checker.sv | 108 ++++++++++
 3 files changed

// File: rtl/memwrite_check_pkg.sv
// Shared types for the data-memory write sequence checker.
package memwrite_check_pkg;

  typedef enum logic [1:0] {CHK_RUN, CHK_PASS, CHK_FAIL} chk_state_t;
  typedef enum logic [1:0] {FC_NONE, FC_ADDR, FC_DATA, FC_TIMEOUT} fail_code_t;

  localparam int CYC_W = 32;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

endpackage

// File: rtl/memwrite_entry_mux.sv
// Selects the expected (address, data) table entry addressed by idx.
module memwrite_entry_mux #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 2,
  parameter int IDX_W   = 2
)(
  input  logic [IDX_W-1:0]          idx,
  input  logic [NUM_EXP*ADDR_W-1:0] exp_addr,
  input  logic [NUM_EXP*DATA_W-1:0] exp_data,
  output logic [ADDR_W-1:0]         sel_addr,
  output logic [DATA_W-1:0]         sel_data
);

  // Out-of-range idx (only after PASS) yields zeros; the value is never compared then.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_addr = exp_addr[i*ADDR_W +: ADDR_W];
        sel_data = exp_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/memwrite_sequence_checker.sv
// Matches core memory writes against an ordered expected table; sticky verdict + timeout.
// Define MEMWRITE_CHECK_DATA_EN to compare write data as well as address.
module memwrite_sequence_checker
  import memwrite_check_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_EXP     = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int IDX_W       = $clog2(NUM_EXP+1)
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memwrite,
  input  logic [ADDR_W-1:0]         dataadr,
  input  logic [DATA_W-1:0]         writedata,
  input  logic [NUM_EXP*ADDR_W-1:0] exp_addr,
  input  logic [NUM_EXP*DATA_W-1:0] exp_data,
  output logic                      done,
  output logic                      pass,
  output logic [1:0]                fail_code,
  output logic [IDX_W-1:0]          fail_idx,
  output logic [IDX_W-1:0]          match_cnt,
  output logic [CYC_W-1:0]          cycle_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EXP-1);
  localparam logic [CYC_W-1:0] TO_CYC   = CYC_W'(TIMEOUT_CYC-1);

  chk_state_t       state, state_nx;
  fail_code_t       fc, fc_nx;
  logic [IDX_W-1:0] idx, idx_nx, fidx, fidx_nx;
  logic [CYC_W-1:0] cyc, cyc_nx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic             addr_hit, data_hit;

  memwrite_entry_mux #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_EXP(NUM_EXP), .IDX_W(IDX_W)
  ) u_mux (
    .idx(idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .sel_addr(sel_addr), .sel_data(sel_data)
  );

  assign addr_hit = (dataadr == sel_addr);
`ifdef MEMWRITE_CHECK_DATA_EN
  assign data_hit = (writedata == sel_data);
`else
  logic unused_wdata;
  assign unused_wdata = ^{writedata, sel_data};
  assign data_hit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CHK_RUN;
      fc    <= FC_NONE;
      idx   <= '0;
      fidx  <= '0;
      cyc   <= '0;
    end else begin
      state <= state_nx;
      fc    <= fc_nx;
      idx   <= idx_nx;
      fidx  <= fidx_nx;
      cyc   <= cyc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    fc_nx    = fc;
    idx_nx   = idx;
    fidx_nx  = fidx;
    cyc_nx   = cyc;
    if (state == CHK_RUN) begin
      if (cyc != CYC_MAX) cyc_nx = cyc + CYC_W'(1);
      if (memwrite) begin
        if (!addr_hit) begin
          state_nx = CHK_FAIL;
          fc_nx    = FC_ADDR;
          fidx_nx  = idx;
        end else if (!data_hit) begin
          state_nx = CHK_FAIL;
          fc_nx    = FC_DATA;
          fidx_nx  = idx;
        end else begin
          idx_nx = idx + IDX_W'(1);
          if (idx == LAST_IDX) state_nx = CHK_PASS;
        end
      end
      // A write-driven verdict on the same edge outranks the timeout.
      if (state_nx == CHK_RUN && cyc == TO_CYC) begin
        state_nx = CHK_FAIL;
        fc_nx    = FC_TIMEOUT;
        fidx_nx  = idx;
      end
    end
  end

  assign done      = (state != CHK_RUN);
  assign pass      = (state == CHK_PASS);
  assign fail_code = fc;
  assign fail_idx  = fidx;
  assign match_cnt = idx;
  assign cycle_cnt = cyc;

endmodule
